// File: rtl/tx_fifo_dut.sv
// Purpose: DEPTH-entry first-word-fall-through FIFO with level, almost-full, sticky overflow and flush.
// Latency: a word pushed at edge N is presented on q (q_valid=1) in the cycle after edge N.
// Backpressure: d_ready drops when full; words offered while full are dropped and flag overflow.
module tx_fifo_dut #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       d_valid,
    output logic                       d_ready,
    input  logic [WIDTH-1:0]           d,
    output logic                       q_valid,
    input  logic                       q_ready,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             ovf;
    logic             push;
    logic             pop;

    // Handshakes depend only on registered state, never on same-cycle inputs.
    assign d_ready     = (cnt < CW'(DEPTH));
    assign q_valid     = (cnt != '0);
    assign almost_full = (cnt >= CW'(AF_LEVEL));
    assign count       = cnt;
    assign overflow    = ovf;
    assign q           = q_valid ? mem[rd_ptr] : '0;

    assign push = d_valid && d_ready;
    assign pop  = q_valid && q_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (d_valid && !d_ready) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage needs no reset: stale entries are hidden behind q_valid.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            mem[wr_ptr] <= d;
        end
    end

endmodule

// File: doc/tx_fifo_dut.md
Name: tx_fifo_dut

Overview:
- Parametrised successor to the single-register d->q DUT used by the TX UVM labs.
- Buffers a stream of WIDTH-bit words in a DEPTH-entry first-word-fall-through FIFO, with valid/ready handshakes on both sides.
- Adds level reporting, an almost-full threshold, a sticky overflow flag and a synchronous flush, so lab sequences can exercise backpressure and error paths.
- Sits behind an extended TX interface, instantiated by the HDL top in place of the plain register DUT.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, FIFO entries; power of two, >=2
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)

Ports:
clk  input  1  rising-edge clock, sole clock domain
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of FIFO contents and overflow flag
d_valid  input  1  producer has word on d
d_ready  output  1  FIFO can accept a word this cycle
d  input  WIDTH  write data
q_valid  output  1  word available on q
q_ready  input  1  consumer takes q this cycle
q  output  WIDTH  head-of-FIFO data
count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH
almost_full  output  1  count >= AF_LEVEL
overflow  output  1  sticky: a write was attempted while full

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset (sampled high at an edge) gives, after that edge:
  - count=0, write and read pointers=0, overflow=0.
  - q_valid=0, d_ready=1, almost_full=0, q=0.
  - Reset overrides flush, push and pop in the same cycle. Mid-stream reset discards all contents with no further outputs.
- Push: occurs when d_valid && d_ready at an edge. d is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop: occurs when q_valid && q_ready at an edge. rd_ptr increments modulo DEPTH.
- Handshake signals, all combinational from registered state with no input-to-output combinational paths:
  - d_ready = (count < DEPTH).
  - q_valid = (count != 0).
  - almost_full = (count >= AF_LEVEL).
- Simultaneous push and pop:
  - Both occur; count is unchanged.
  - When full, d_ready=0, so a same-cycle pop does not enable a push (no pass-through when full).
  - When empty, q_valid=0, so there is no pop; the push lands and count becomes 1.
- Latency: a word pushed at edge N appears on q with q_valid=1 in the cycle after edge N (first-word fall-through, one cycle).
- q data: q = mem[rd_ptr] while q_valid=1, and q=0 while q_valid=0.
  - q stays stable while q_valid && !q_ready.
  - Data order is strictly FIFO.
- count: incremented on push-only, decremented on pop-only, otherwise held. It never exceeds DEPTH or drops below 0.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are decided from count, not pointer compare.
- Overflow:
  - Set at any edge where d_valid=1 and d_ready=0.
  - The offered word is dropped and FIFO contents are unaffected.
  - Stays set until reset or flush.
- Flush (when reset=0):
  - At the edge: count=0, pointers=0, overflow=0.
  - A same-cycle push is discarded and does not set overflow; a same-cycle pop is ignored.
  - d_ready=1 and q_valid=0 in the following cycle.
- Words pushed after reset/flush but never written remain unobservable, because q is gated by q_valid.

Test Plan:
All scenarios use WIDTH=8, DEPTH=4, AF_LEVEL=3.
1. Reset then idle -> count=0, q_valid=0, d_ready=1, q=0x00, almost_full=0, overflow=0.
2. Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with q_ready=0 -> q=0x11 with q_valid=1 the cycle after the first push; almost_full=1 after the third push; count=4 and d_ready=0 after the fourth. Then q_ready=1 for 4 cycles -> q reads 0x11, 0x22, 0x33, 0x44, then q_valid=0 and count=0.
3. Full FIFO, d_valid=1 with d=0x55 -> overflow=1, count stays 4, and 0x55 is never output. A later pop with push in the next cycle -> overflow stays 1.
4. Count=2, simultaneous push 0x66 and pop for 6 cycles (pointers wrap) -> count stays 2, and outputs match input order across the wrap.
5. Count=3 with overflow=1; flush=1 with d_valid=1, d=0x77, q_ready=1 -> next cycle count=0, q_valid=0, overflow=0, and 0x77 is never output.
6. Reset asserted mid-stream while count=2 and push/pop are active -> after the edge, all outputs are at reset values. A subsequent push of 0x88 appears on q one cycle later.
